// File: rtl/router_pkg.sv
// Shared constants for the router packet register: checksum mode encodings
// and default parameter values.
package router_pkg;

  localparam int CHK_XOR = 0;
  localparam int CHK_SUM = 1;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_N_CH       = 3;
  localparam int DEF_HOLD_DEPTH = 2;
  localparam int DEF_CHK_MODE   = CHK_XOR;

endpackage

// File: rtl/router_hold_fifo.sv
// Small circular buffer that parks payload bytes while the output FIFO is full.
// Pushes to a full buffer and pops from an empty one are ignored.
module router_hold_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok  = pop_i && !empty_o;
    push_ok = push_i && (!full_o || pop_ok);
    cnt_d   = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + CW'(1);
    else if (pop_ok && !push_ok) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/router_pkt_reg.sv
// Router packet register: latches the header, forwards payload bytes to the
// selected FIFO (parking them while it is full) and checks the trailing parity byte.
module router_pkt_reg
  import router_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int N_CH       = DEF_N_CH,
  parameter int HOLD_DEPTH = DEF_HOLD_DEPTH,
  parameter int CHK_MODE   = DEF_CHK_MODE
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            pkt_valid,
  input  logic [DATA_W-1:0]               data_in,
  input  logic                            fifo_full,
  input  logic                            detect_add,
  input  logic                            lfd_state,
  input  logic                            ld_state,
  input  logic                            laf_state,
  input  logic                            full_state,
  input  logic                            rst_int_reg,
  output logic [DATA_W-1:0]               dout,
  output logic                            dout_valid,
  output logic                            parity_done,
  output logic                            low_pkt_valid,
  output logic                            err,
  output logic                            addr_err,
  output logic                            hold_ovf,
  output logic [$clog2(HOLD_DEPTH+1)-1:0] hold_cnt
);
  logic [DATA_W-1:0] dout_q, hb_q, pp_q, acc_q, acc_d, emit_byte, hold_head;
  logic dout_valid_q, parity_done_q, pd_prev_q, low_pkt_valid_q;
  logic err_q, addr_err_q, hold_ovf_q;
  logic hold_full, hold_empty, push, pop, emit, drop, addr_ok, ld_act;
  logic unused_full_state;

  // full_state only stalls the controller; this block holds everything then.
  assign unused_full_state = full_state;
  assign addr_ok = int'(data_in[1:0]) < N_CH;
  assign ld_act  = ld_state && !detect_add && !lfd_state;

  always_comb begin
    emit      = 1'b0;
    emit_byte = hb_q;
    push      = 1'b0;
    pop       = 1'b0;
    drop      = 1'b0;
    if (!detect_add) begin
      if (lfd_state) begin
        emit = 1'b1;
      end else if (ld_state) begin
        if (pkt_valid) begin
          // Bytes bypass the hold buffer only when nothing older is parked.
          if (!fifo_full && hold_empty) begin
            emit      = 1'b1;
            emit_byte = data_in;
          end else if (hold_full) begin
            drop = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end else if (laf_state && !fifo_full && !hold_empty) begin
        pop       = 1'b1;
        emit      = 1'b1;
        emit_byte = hold_head;
      end
    end
    acc_d = acc_q;
    if (emit) begin
      if (lfd_state)               acc_d = hb_q;
      else if (CHK_MODE == CHK_SUM) acc_d = acc_q + emit_byte;
      else                          acc_d = acc_q ^ emit_byte;
    end
  end

  router_hold_fifo #(
    .W     (DATA_W),
    .DEPTH (HOLD_DEPTH)
  ) u_hold (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .clr_i   (detect_add),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (data_in),
    .head_o  (hold_head),
    .cnt_o   (hold_cnt),
    .full_o  (hold_full),
    .empty_o (hold_empty)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout_q          <= '0;
      hb_q            <= '0;
      pp_q            <= '0;
      acc_q           <= '0;
      dout_valid_q    <= 1'b0;
      parity_done_q   <= 1'b0;
      pd_prev_q       <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
      addr_err_q      <= 1'b0;
      hold_ovf_q      <= 1'b0;
    end else begin
      dout_valid_q <= emit;
      pd_prev_q    <= parity_done_q;
      if (emit) begin
        dout_q <= emit_byte;
        acc_q  <= acc_d;
      end
      if (detect_add) begin
        parity_done_q <= 1'b0;
        err_q         <= 1'b0;
        hold_ovf_q    <= 1'b0;
        acc_q         <= '0;
        addr_err_q    <= pkt_valid && !addr_ok;
        if (pkt_valid && addr_ok) hb_q <= data_in;
      end else begin
        if (drop) hold_ovf_q <= 1'b1;
        if (ld_act && !pkt_valid) pp_q <= data_in;
        if (low_pkt_valid_q && hold_empty && !emit) parity_done_q <= 1'b1;
        // Compare once, on the cycle after parity_done rises.
        if (parity_done_q && !pd_prev_q) err_q <= (acc_q != pp_q);
      end
      if (rst_int_reg) low_pkt_valid_q <= 1'b0;
      else if (ld_act && !pkt_valid) low_pkt_valid_q <= 1'b1;
    end
  end

  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;
  assign addr_err      = addr_err_q;
  assign hold_ovf      = hold_ovf_q;

endmodule

// File: tb/tb_router_pkt_reg.sv
// Bench for router_pkt_reg: an XOR-mode and a SUM-mode instance share stimulus;
// a queue-based model predicts emitted bytes, hold occupancy and checksum errors.
module tb_router_pkt_reg;
  localparam int N_CH       = 3;
  localparam int HOLD_DEPTH = 2;

  logic       clock, resetn, pkt_valid, fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] data_in;
  logic [7:0] dout0, dout1;
  logic       dv0, dv1, pd0, pd1, lpv0, lpv1, err0, err1, aerr0, aerr1, ovf0, ovf1;
  logic [1:0] hcnt0, hcnt1;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] hold_m[$];
  logic [7:0] pay_q[$];
  bit         full_q[$];
  logic [7:0] hb_m, last_dout;
  bit         ovf_m, drain_rand;

  router_pkt_reg #(.DATA_W(8), .N_CH(N_CH), .HOLD_DEPTH(HOLD_DEPTH), .CHK_MODE(0)) dut_xor (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout0), .dout_valid(dv0), .parity_done(pd0),
    .low_pkt_valid(lpv0), .err(err0), .addr_err(aerr0), .hold_ovf(ovf0), .hold_cnt(hcnt0)
  );

  router_pkt_reg #(.DATA_W(8), .N_CH(N_CH), .HOLD_DEPTH(HOLD_DEPTH), .CHK_MODE(1)) dut_sum (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout1), .dout_valid(dv1), .parity_done(pd1),
    .low_pkt_valid(lpv1), .err(err1), .addr_err(aerr1), .hold_ovf(ovf1), .hold_cnt(hcnt1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (dv0) begin
      got_q.push_back(dout0);
      last_dout = dout0;
    end else begin
      chk("dout_held", 32'(dout0), 32'(last_dout));
    end
    chk("hold_cnt", 32'(hcnt0), 32'(hold_m.size()));
    chk("dout_same", 32'({dout1, dv1}), 32'({dout0, dv0}));
  endtask

  task automatic clear_inputs();
    pkt_valid = 0; fifo_full = 0; detect_add = 0; lfd_state = 0;
    ld_state = 0; laf_state = 0; full_state = 0; rst_int_reg = 0; data_in = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_x"}, 32'({dout0, dv0, pd0, lpv0, err0, aerr0, ovf0, hcnt0}), 32'h0);
    chk({tag, "_s"}, 32'({dout1, dv1, pd1, lpv1, err1, aerr1, ovf1, hcnt1}), 32'h0);
  endtask

  task automatic detect_lfd(input logic [7:0] hdr);
    bit bad;
    bad = int'(hdr[1:0]) >= N_CH;
    if (!bad) hb_m = hdr;
    exp_q.delete(); got_q.delete(); hold_m.delete(); ovf_m = 0;
    detect_add = 1; pkt_valid = 1; data_in = hdr;
    tick();
    detect_add = 0;
    chk("addr_err", 32'(aerr0), 32'(bad));
    chk("pd_cleared", 32'({pd0, err0, ovf0}), 32'h0);
    lfd_state = 1; data_in = 8'($urandom);
    exp_q.push_back(hb_m);
    tick();
    lfd_state = 0;
  endtask

  task automatic ld_byte(input logic [7:0] b, input bit full, input bit laf);
    ld_state = 1; laf_state = laf; pkt_valid = 1; fifo_full = full; data_in = b;
    if (!full && hold_m.size() == 0) exp_q.push_back(b);
    else if (hold_m.size() < HOLD_DEPTH) hold_m.push_back(b);
    else ovf_m = 1;
    tick();
    ld_state = 0; laf_state = 0; fifo_full = 0;
  endtask

  task automatic laf_cycle(input bit full);
    laf_state = 1; fifo_full = full;
    if (!full && hold_m.size() > 0) exp_q.push_back(hold_m.pop_front());
    tick();
    laf_state = 0; fifo_full = 0;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par);
    logic [7:0] x, s;
    detect_lfd(hdr);
    foreach (pay_q[i]) ld_byte(pay_q[i], full_q[i], 1'($urandom_range(0, 1)));
    for (int n = 0; n < 40 && hold_m.size() > 0; n++)
      laf_cycle(drain_rand && n < 20 && $urandom_range(0, 2) == 0);
    chk("drain_done", 32'(hold_m.size()), 32'h0);
    chk("hold_ovf", 32'(ovf0), 32'(ovf_m));
    ld_state = 1; pkt_valid = 0; data_in = par;
    tick();
    ld_state = 0; data_in = 8'h00;
    chk("lpv_set", 32'(lpv0), 32'h1);
    chk("pd_wait", 32'(pd0), 32'h0);
    tick();
    chk("pd_rise", 32'({pd0, pd1}), 32'h3);
    chk("err_not_yet", 32'(err0), 32'h0);
    tick();
    x = 8'h00; s = 8'h00;
    foreach (exp_q[i]) begin
      x = x ^ exp_q[i];
      s = s + exp_q[i];
    end
    chk("err_xor", 32'(err0), 32'(x != par));
    chk("err_sum", 32'(err1), 32'(s != par));
    chk("emit_count", 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) if (i < got_q.size()) chk("emit_byte", 32'(got_q[i]), 32'(exp_q[i]));
    rst_int_reg = 1;
    tick();
    rst_int_reg = 0;
    chk("lpv_clear", 32'(lpv0), 32'h0);
    chk("pd_hold", 32'(pd0), 32'h1);
  endtask

  initial begin
    int len;
    logic [7:0] hdr, par;
    clear_inputs();
    resetn = 0; hb_m = 0; last_dout = 0; drain_rand = 0;
    #12;
    check_all_zero("reset");
    resetn = 1;

    // Basic XOR packet: 01^11^22 = 32
    pay_q = '{8'h11, 8'h22}; full_q = '{0, 0};
    send_pkt(8'h01, 8'h32);
    send_pkt(8'h01, 8'h33);
    // Sum wraps: 02+FF+03 = 04
    pay_q = '{8'hFF, 8'h03}; full_q = '{0, 0};
    send_pkt(8'h02, 8'h04);
    // Hold buffer fills; third byte overflows
    pay_q = '{8'hA0, 8'hA1, 8'hA2}; full_q = '{1, 1, 1};
    send_pkt(8'h01, 8'h00);
    // Bad address keeps the previous header
    pay_q = '{8'h55}; full_q = '{0};
    send_pkt(8'h03, 8'h54);
    pay_q = '{8'h66}; full_q = '{1};
    send_pkt(8'h00, 8'h66);

    // Reset mid-payload with bytes parked
    detect_lfd(8'h02);
    ld_byte(8'h10, 1, 0);
    ld_byte(8'h20, 1, 0);
    resetn = 0;
    #2;
    check_all_zero("midreset");
    clear_inputs();
    hb_m = 0; last_dout = 0; hold_m.delete();
    resetn = 1;
    pay_q = '{8'h10, 8'h20}; full_q = '{0, 0};
    send_pkt(8'h02, 8'h32);

    drain_rand = 1;
    for (int p = 0; p < 10; p++) begin
      pay_q.delete(); full_q.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        pay_q.push_back(8'($urandom));
        full_q.push_back($urandom_range(0, 3) == 0);
      end
      hdr = 8'($urandom);
      par = (int'(hdr[1:0]) < N_CH) ? hdr : hb_m;
      foreach (pay_q[i]) par = par ^ pay_q[i];
      if ($urandom_range(0, 1) == 0) par = 8'($urandom);
      send_pkt(hdr, par);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
